commit_rob: RTL and testbench

//  In-order reorder buffer that sits directly upstream of the commit stage. It allocates one

---
 rtl/commit_rob.sv | 149 ++++++++++++++
 tb/tb_commit_rob.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/commit_rob.sv
// In-order reorder buffer feeding the commit stage: allocates ids on issue, marks entries done
// on writeback, and presents the oldest done entries in program order for retirement.
module commit_rob #(
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned NR_WB_PORTS     = 4,
  parameter int unsigned XLEN            = 64,
  parameter int unsigned VLEN            = 64,
  parameter int unsigned ID_W            = $clog2(NR_ENTRIES)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       flush_i,
  input  logic                                       issue_valid_i,
  output logic                                       issue_ready_o,
  input  logic [VLEN-1:0]                            issue_pc_i,
  input  logic [4:0]                                 issue_rd_i,
  input  logic [3:0]                                 issue_fu_i,
  output logic [ID_W-1:0]                            issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                     wb_valid_i,
  input  logic [NR_WB_PORTS*ID_W-1:0]                wb_trans_id_i,
  input  logic [NR_WB_PORTS*XLEN-1:0]                wb_result_i,
  input  logic [NR_WB_PORTS-1:0]                     wb_ex_valid_i,
  input  logic [NR_WB_PORTS*XLEN-1:0]                wb_ex_cause_i,
  output logic [NR_COMMIT_PORTS-1:0]                 commit_valid_o,
  output logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]       commit_pc_o,
  output logic [NR_COMMIT_PORTS-1:0][4:0]            commit_rd_o,
  output logic [NR_COMMIT_PORTS-1:0][3:0]            commit_fu_o,
  output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]       commit_result_o,
  output logic [NR_COMMIT_PORTS-1:0]                 commit_ex_valid_o,
  output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]       commit_ex_cause_o,
  output logic [NR_COMMIT_PORTS-1:0][ID_W-1:0]       commit_trans_id_o,
  input  logic [NR_COMMIT_PORTS-1:0]                 commit_ack_i
);

  localparam int unsigned CNT_W = ID_W + 1;

  // Handshakes: issue transfers when issue_valid_i & issue_ready_o at a rising edge;
  // commit port k retires when commit_valid_o[k] & commit_ack_i[k] and all lower ports retire.

  logic [ID_W-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d, retire_cnt;
  logic [NR_ENTRIES-1:0]  occ_q, done_q, ex_valid_q;
  logic [VLEN-1:0]        pc_q       [NR_ENTRIES];
  logic [4:0]             rd_q       [NR_ENTRIES];
  logic [3:0]             fu_q       [NR_ENTRIES];
  logic [XLEN-1:0]        result_q   [NR_ENTRIES];
  logic [XLEN-1:0]        ex_cause_q [NR_ENTRIES];

  logic                        issue_fire;
  logic [NR_ENTRIES-1:0]       retire_mask;
  logic [ID_W-1:0]             commit_idx [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS-1:0]  commit_valid, retire_port;
  logic                        valid_chain, retire_chain;
  logic [NR_WB_PORTS-1:0]      wb_hit;
  logic [ID_W-1:0]             wb_id [NR_WB_PORTS];

  assign issue_ready_o    = (count_q != CNT_W'(NR_ENTRIES));
  assign issue_fire       = issue_valid_i & issue_ready_o;
  assign issue_trans_id_o = tail_q;

  // Commit window: a port is valid only if every older port is valid too.
  always_comb begin
    commit_valid = '0;
    retire_port  = '0;
    retire_cnt   = '0;
    retire_mask  = '0;
    valid_chain  = 1'b1;
    retire_chain = 1'b1;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      commit_idx[k]   = head_q + ID_W'(k);
      commit_valid[k] = valid_chain & occ_q[commit_idx[k]] & done_q[commit_idx[k]];
      valid_chain     = commit_valid[k];
      retire_port[k]  = retire_chain & commit_ack_i[k] & commit_valid[k];
      retire_chain    = retire_port[k];
      retire_cnt      = retire_cnt + CNT_W'(retire_port[k]);
      if (retire_port[k]) retire_mask[commit_idx[k]] = 1'b1;
    end
  end

  always_comb begin
    wb_hit = '0;
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      wb_id[p]  = wb_trans_id_i[p*ID_W +: ID_W];
      wb_hit[p] = wb_valid_i[p] & occ_q[wb_id[p]] & ~done_q[wb_id[p]];
    end
  end

  assign tail_d  = tail_q + ID_W'(issue_fire);
  assign head_d  = head_q + retire_cnt[ID_W-1:0];
  assign count_d = count_q + CNT_W'(issue_fire) - retire_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Later writeback ports overwrite earlier ones, so the highest-index port wins on an id clash.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      occ_q  <= '0;
      done_q <= '0;
    end else begin
      for (int e = 0; e < NR_ENTRIES; e++) begin
        if (retire_mask[e]) begin
          occ_q[e]  <= 1'b0;
          done_q[e] <= 1'b0;
        end
      end
      if (issue_fire) begin
        occ_q[tail_q]      <= 1'b1;
        done_q[tail_q]     <= 1'b0;
        ex_valid_q[tail_q] <= 1'b0;
        pc_q[tail_q]       <= issue_pc_i;
        rd_q[tail_q]       <= issue_rd_i;
        fu_q[tail_q]       <= issue_fu_i;
      end
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_hit[p]) begin
          done_q[wb_id[p]]     <= 1'b1;
          result_q[wb_id[p]]   <= wb_result_i[p*XLEN +: XLEN];
          ex_valid_q[wb_id[p]] <= wb_ex_valid_i[p];
          ex_cause_q[wb_id[p]] <= wb_ex_cause_i[p*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    commit_valid_o = commit_valid;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      commit_pc_o[k]       = pc_q[commit_idx[k]];
      commit_rd_o[k]       = rd_q[commit_idx[k]];
      commit_fu_o[k]       = fu_q[commit_idx[k]];
      commit_result_o[k]   = result_q[commit_idx[k]];
      commit_ex_valid_o[k] = ex_valid_q[commit_idx[k]];
      commit_ex_cause_o[k] = ex_cause_q[commit_idx[k]];
      commit_trans_id_o[k] = commit_idx[k];
    end
  end

endmodule

// File: tb/tb_commit_rob.sv
// Directed bench for commit_rob: reset, out-of-order writeback, full buffer, wrapping stream,
// flush priority, partial acks, exception entries and writeback-port priority.
module tb_commit_rob;

  localparam int NE = 8, NCP = 2, NWB = 4, XLEN = 64, VLEN = 64, IDW = 3;

  logic                        clk = 1'b0;
  logic                        rst, flush, issue_valid, issue_ready;
  logic [VLEN-1:0]             issue_pc;
  logic [4:0]                  issue_rd;
  logic [3:0]                  issue_fu;
  logic [IDW-1:0]              issue_trans_id;
  logic [NWB-1:0]              wb_valid, wb_ex_valid;
  logic [NWB*IDW-1:0]          wb_trans_id;
  logic [NWB*XLEN-1:0]         wb_result, wb_ex_cause;
  logic [NCP-1:0]              commit_valid, commit_ex_valid, commit_ack;
  logic [NCP-1:0][VLEN-1:0]    commit_pc;
  logic [NCP-1:0][4:0]         commit_rd;
  logic [NCP-1:0][3:0]         commit_fu;
  logic [NCP-1:0][XLEN-1:0]    commit_result, commit_ex_cause;
  logic [NCP-1:0][IDW-1:0]     commit_trans_id;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_pc;

  commit_rob #(.NR_ENTRIES(NE), .NR_COMMIT_PORTS(NCP), .NR_WB_PORTS(NWB),
               .XLEN(XLEN), .VLEN(VLEN)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_pc_i(issue_pc), .issue_rd_i(issue_rd), .issue_fu_i(issue_fu),
    .issue_trans_id_o(issue_trans_id),
    .wb_valid_i(wb_valid), .wb_trans_id_i(wb_trans_id), .wb_result_i(wb_result),
    .wb_ex_valid_i(wb_ex_valid), .wb_ex_cause_i(wb_ex_cause),
    .commit_valid_o(commit_valid), .commit_pc_o(commit_pc), .commit_rd_o(commit_rd),
    .commit_fu_o(commit_fu), .commit_result_o(commit_result),
    .commit_ex_valid_o(commit_ex_valid), .commit_ex_cause_o(commit_ex_cause),
    .commit_trans_id_o(commit_trans_id), .commit_ack_i(commit_ack)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; issue_valid = 0; issue_pc = '0; issue_rd = '0; issue_fu = '0;
    wb_valid = '0; wb_trans_id = '0; wb_result = '0; wb_ex_valid = '0; wb_ex_cause = '0;
    commit_ack = '0;
  endtask

  task automatic set_issue(input logic [VLEN-1:0] pc);
    issue_valid = 1; issue_pc = pc; issue_rd = pc[6:2]; issue_fu = pc[5:2];
  endtask

  task automatic set_wb(input int p, input logic [IDW-1:0] id, input logic [XLEN-1:0] res,
                        input logic ex, input logic [XLEN-1:0] cause);
    wb_valid[p] = 1'b1;
    wb_trans_id[p*IDW +: IDW] = id;
    wb_result[p*XLEN +: XLEN] = res;
    wb_ex_valid[p] = ex;
    wb_ex_cause[p*XLEN +: XLEN] = cause;
  endtask

  initial begin
    clear_inputs();
    // reset
    rst = 1;
    step(); step();
    check("rst_ready", 64'(issue_ready), 64'd1);
    check("rst_tid", 64'(issue_trans_id), 64'd0);
    check("rst_valid", 64'(commit_valid), 64'd0);
    rst = 0;

    // three issues, writebacks in reverse order
    for (int i = 0; i < 3; i++) begin
      set_issue(64'h100 + 64'(4*i));
      check("t2_tid", 64'(issue_trans_id), 64'(i));
      step();
    end
    clear_inputs();
    set_wb(0, 3'd2, 64'h22, 0, 0); step(); clear_inputs();
    check("t2_valid_id2", 64'(commit_valid), 64'b00);
    set_wb(1, 3'd1, 64'h11, 0, 0); step(); clear_inputs();
    check("t2_valid_id1", 64'(commit_valid), 64'b00);
    set_wb(2, 3'd0, 64'hAA, 0, 0); step(); clear_inputs();
    check("t2_valid_all", 64'(commit_valid), 64'b11);
    check("t2_pc0", commit_pc[0], 64'h100);
    check("t2_result0", commit_result[0], 64'hAA);
    check("t2_pc1", commit_pc[1], 64'h104);
    check("t2_result1", commit_result[1], 64'h11);
    commit_ack = 2'b11; step(); clear_inputs();
    check("t2_valid_after_ack", 64'(commit_valid), 64'b01);
    check("t2_tid0_after_ack", 64'(commit_trans_id[0]), 64'd2);
    check("t2_pc0_after_ack", commit_pc[0], 64'h108);
    commit_ack = 2'b01; step(); clear_inputs();
    check("t2_empty", 64'(commit_valid), 64'b00);

    // fill all 8 entries (ids 3..7,0..2), no writebacks
    for (int i = 0; i < NE; i++) begin
      check("t3_ready_fill", 64'(issue_ready), 64'd1);
      set_issue(64'h200 + 64'(4*i));
      step();
    end
    check("t3_full_ready", 64'(issue_ready), 64'd0);
    check("t3_full_tid", 64'(issue_trans_id), 64'd3);
    step();
    check("t3_no_issue_when_full", 64'(issue_trans_id), 64'd3);
    clear_inputs();
    set_wb(3, 3'd3, 64'h5, 0, 0); step(); clear_inputs();
    check("t3_head_valid", 64'(commit_valid), 64'b01);
    commit_ack = 2'b01; set_issue(64'h300);
    check("t3_ready_during_ack", 64'(issue_ready), 64'd0);
    step(); clear_inputs();
    check("t3_ready_after_ack", 64'(issue_ready), 64'd1);
    check("t3_tid_after_ack", 64'(issue_trans_id), 64'd3);
    flush = 1; step(); clear_inputs();
    check("t3_flush_ready", 64'(issue_ready), 64'd1);
    check("t3_flush_tid", 64'(issue_trans_id), 64'd0);

    // stream 20 instructions, issue overlapping the ack of the previous one
    for (int i = 0; i < 20; i++) begin
      set_issue(64'h1000 + 64'(4*i));
      if (i > 0) commit_ack = 2'b01;
      check("t4_ready", 64'(issue_ready), 64'd1);
      check("t4_tid", 64'(issue_trans_id), 64'(i % NE));
      exp_q.push_back(64'h1000 + 64'(4*i));
      step(); clear_inputs();
      set_wb(i % NWB, 3'(i % NE), 64'(i), 0, 0); step(); clear_inputs();
      check("t4_valid", 64'(commit_valid), 64'b01);
      check("t4_commit_tid", 64'(commit_trans_id[0]), 64'(i % NE));
      if (exp_q.size() == 0) begin
        check("t4_queue_empty", 64'd1, 64'd0);
      end else begin
        exp_pc = exp_q.pop_front();
        check("t4_pc", commit_pc[0], exp_pc);
      end
      check("t4_result", commit_result[0], 64'(i));
    end
    commit_ack = 2'b01; step(); clear_inputs();
    check("t4_drained", 64'(commit_valid), 64'b00);
    check("t4_tail_wrapped", 64'(issue_trans_id), 64'd4);

    // count=5, then flush with issue+wb+ack in the same cycle
    for (int i = 0; i < 5; i++) begin
      set_issue(64'h400 + 64'(4*i)); step();
    end
    clear_inputs();
    set_wb(0, 3'd4, 64'h1, 0, 0); step(); clear_inputs();
    check("t5_head_valid", 64'(commit_valid), 64'b01);
    flush = 1; set_issue(64'h500); set_wb(1, 3'd5, 64'h2, 0, 0); commit_ack = 2'b01;
    step(); clear_inputs();
    check("t5_tid", 64'(issue_trans_id), 64'd0);
    check("t5_valid", 64'(commit_valid), 64'b00);
    check("t5_ready", 64'(issue_ready), 64'd1);
    set_wb(0, 3'd0, 64'h3, 0, 0); step(); clear_inputs();
    check("t5_wb_unoccupied", 64'(commit_valid), 64'b00);

    // partial acks, exceptions, writeback priority
    for (int i = 0; i < 4; i++) begin
      set_issue(64'h600 + 64'(4*i)); step();
    end
    clear_inputs();
    set_wb(0, 3'd0, 64'hA0, 0, 0); set_wb(1, 3'd1, 64'hA1, 0, 0); step(); clear_inputs();
    check("t6_valid", 64'(commit_valid), 64'b11);
    commit_ack = 2'b10; step(); clear_inputs();
    check("t6_ack10_valid", 64'(commit_valid), 64'b11);
    check("t6_ack10_tid0", 64'(commit_trans_id[0]), 64'd0);
    set_wb(2, 3'd3, 64'h33, 1, 64'd2);
    set_wb(0, 3'd2, 64'h11, 0, 0); set_wb(3, 3'd2, 64'h99, 0, 0);
    step(); clear_inputs();
    set_wb(1, 3'd3, 64'h77, 0, 0); step(); clear_inputs();
    commit_ack = 2'b11; step(); clear_inputs();
    check("t6_valid_after", 64'(commit_valid), 64'b11);
    check("t6_prio_result", commit_result[0], 64'h99);
    check("t6_ex0", 64'(commit_ex_valid[0]), 64'd0);
    check("t6_tid1", 64'(commit_trans_id[1]), 64'd3);
    check("t6_ex1", 64'(commit_ex_valid[1]), 64'd1);
    check("t6_cause1", commit_ex_cause[1], 64'd2);
    check("t6_result1_kept", commit_result[1], 64'h33);
    check("t6_pc1", commit_pc[1], 64'h60C);
    commit_ack = 2'b11; step(); clear_inputs();
    check("t6_drained", 64'(commit_valid), 64'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
